// File: rtl/game_score_counter.sv
// game_score_counter: run-state FSM and score keeping for the dino game.
// Keeps a binary score, a session high score and an incrementally
// maintained BCD copy of the score, and pulses on day/night milestones.
module game_score_counter #(
  parameter int TICK_CYCLES = 4_000_000,
  parameter int MAX_SCORE   = 9999,
  parameter int MILESTONE   = 700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        crash,
  output logic [13:0] game_score,
  output logic [15:0] score_bcd,
  output logic [13:0] high_score,
  output logic [1:0]  run_state,
  output logic        milestone
);

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int MW = (MILESTONE > 2) ? $clog2(MILESTONE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [MW-1:0] MS_LAST   = MW'(MILESTONE - 1);
  localparam logic [13:0]   SCORE_MAX = 14'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t          state_reg;
  logic [TW-1:0]   tick_reg;
  logic [MW-1:0]   ms_reg;
  logic [13:0]     score_reg;
  logic [15:0]     bcd_reg;
  logic [13:0]     high_reg;
  logic            milestone_reg;

  // Next BCD value: each digit rolls 9->0 and carries when every lower digit
  // is 9. Never evaluated at 9999 because the score saturates below that.
  logic [15:0] bcd_inc;
  logic [3:0]  bcd_carry;

  assign bcd_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = bcd_reg[4*gi +: 4];
      assign bcd_inc[4*gi +: 4] = !bcd_carry[gi]    ? digit :
                                  (digit == 4'd9)   ? 4'd0  :
                                                      digit + 4'd1;
      if (gi < 3) begin : g_carry
        assign bcd_carry[gi+1] = bcd_carry[gi] && (digit == 4'd9);
      end
    end
  endgenerate

  logic tick_wrap;
  assign tick_wrap = (tick_reg == TICK_LAST);

  // Run-state FSM with all counters and registered outputs; crash wins over
  // a coincident tick, start is only honoured outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tick_reg      <= '0;
      ms_reg        <= '0;
      score_reg     <= '0;
      bcd_reg       <= '0;
      high_reg      <= '0;
      milestone_reg <= 1'b0;
    end else begin
      milestone_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (crash) begin
            state_reg <= OVER;
            if (score_reg > high_reg) begin
              high_reg <= score_reg;
            end
          end else if (tick_wrap) begin
            tick_reg <= '0;
            if (score_reg < SCORE_MAX) begin
              score_reg <= score_reg + 14'd1;
              bcd_reg   <= bcd_inc;
              if (ms_reg == MS_LAST) begin
                ms_reg        <= '0;
                milestone_reg <= 1'b1;
              end else begin
                ms_reg <= ms_reg + MW'(1);
              end
            end
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        default: begin
          // IDLE and OVER: hold everything until a start restarts the run.
          if (start) begin
            state_reg <= RUN;
            tick_reg  <= '0;
            ms_reg    <= '0;
            score_reg <= '0;
            bcd_reg   <= '0;
          end
        end
      endcase
    end
  end

  assign game_score = score_reg;
  assign score_bcd  = bcd_reg;
  assign high_score = high_reg;
  assign run_state  = state_reg;
  assign milestone  = milestone_reg;

endmodule

// File: tb/tb_game_score_counter.sv
// Testbench for game_score_counter: two instances with different parameters,
// a cycle-level arithmetic model, a per-cycle compare process and directed
// literal checks.
module tb_game_score_counter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: TICK_CYCLES=4, MAX_SCORE=7, MILESTONE=3
  logic        rst_a, start_a, crash_a;
  logic [13:0] score_a, high_a;
  logic [15:0] bcd_a;
  logic [1:0]  state_a;
  logic        ms_a;

  // Instance B: TICK_CYCLES=2, MAX_SCORE=9999, MILESTONE=700
  logic        rst_b, start_b, crash_b;
  logic [13:0] score_b, high_b;
  logic [15:0] bcd_b;
  logic [1:0]  state_b;
  logic        ms_b;

  game_score_counter #(.TICK_CYCLES(4), .MAX_SCORE(7), .MILESTONE(3)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .crash(crash_a),
    .game_score(score_a), .score_bcd(bcd_a), .high_score(high_a),
    .run_state(state_a), .milestone(ms_a)
  );

  game_score_counter #(.TICK_CYCLES(2), .MAX_SCORE(9999), .MILESTONE(700)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .crash(crash_b),
    .game_score(score_b), .score_bcd(bcd_b), .high_score(high_b),
    .run_state(state_b), .milestone(ms_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural model: score is simply elapsed run cycles / TICK, clipped.
  int m_state[2], m_score[2], m_high[2], m_elapsed[2];
  bit m_ms[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_score[i] = 0; m_high[i] = 0; m_elapsed[i] = 0; m_ms[i] = 0;
    end
  end

  task automatic model_step(input int i, input bit r, input bit s, input bit c,
                            input int tick, input int maxs, input int mstone);
    int n;
    m_ms[i] = 1'b0;
    if (r) begin
      m_state[i] = 0; m_score[i] = 0; m_high[i] = 0; m_elapsed[i] = 0;
    end else if (m_state[i] != 1) begin
      if (s) begin
        m_state[i] = 1; m_score[i] = 0; m_elapsed[i] = 0;
      end
    end else if (c) begin
      m_state[i] = 2;
      if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
    end else begin
      m_elapsed[i]++;
      if (m_elapsed[i] % tick == 0) begin
        n = m_elapsed[i] / tick;
        if (n <= maxs) begin
          m_score[i] = n;
          if (n % mstone == 0) m_ms[i] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, rst_a, start_a, crash_a, 4, 7, 3);
    model_step(1, rst_b, start_b, crash_b, 2, 9999, 700);
  end

  // Every cycle, compare both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_state", state_a, m_state[0]);
      check("a_score", score_a, m_score[0]);
      check("a_bcd",   bcd_a,   to_bcd(m_score[0]));
      check("a_high",  high_a,  m_high[0]);
      check("a_ms",    ms_a,    m_ms[0]);
      check("b_state", state_b, m_state[1]);
      check("b_score", score_b, m_score[1]);
      check("b_bcd",   bcd_b,   to_bcd(m_score[1]));
      check("b_high",  high_b,  m_high[1]);
      check("b_ms",    ms_b,    m_ms[1]);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input bit s, input bit c);
    start_a = s; crash_a = c;
    @(negedge clk);
    start_a = 1'b0; crash_a = 1'b0;
  endtask

  task automatic pulse_b(input bit s, input bit c);
    start_b = s; crash_b = c;
    @(negedge clk);
    start_b = 1'b0; crash_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; crash_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; crash_b = 1'b0;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    chk_en = 1'b1;
    check("lit_reset_state", state_a, 0);
    check("lit_reset_score", score_a, 0);
    check("lit_reset_high",  high_a, 0);

    // Instance A: start timing with TICK_CYCLES=4
    wait_n(3);
    check("lit_idle_hold", state_a, 0);
    pulse_a(1, 0);
    check("lit_start_state", state_a, 1);
    check("lit_start_score", score_a, 0);
    wait_n(3);
    check("lit_edge3_score", score_a, 0);
    wait_n(1);
    check("lit_edge4_score", score_a, 1);
    wait_n(8);
    check("lit_edge12_score", score_a, 3);
    check("lit_edge12_bcd", bcd_a, 16'h0003);
    check("lit_ms3", ms_a, 1);
    wait_n(1);
    check("lit_ms3_drop", ms_a, 0);
    wait_n(7);
    check("lit_score5", score_a, 5);
    pulse_a(0, 1);
    check("lit_crash5_state", state_a, 2);
    check("lit_crash5_score", score_a, 5);
    check("lit_crash5_high", high_a, 5);
    pulse_a(0, 1);
    wait_n(1);
    pulse_a(0, 1);
    check("lit_over_crash_state", state_a, 2);
    check("lit_over_crash_high", high_a, 5);

    // Restart, crash at 2: high score keeps 5
    pulse_a(1, 0);
    check("lit_restart_score", score_a, 0);
    wait_n(8);
    pulse_a(0, 1);
    check("lit_crash2_score", score_a, 2);
    check("lit_crash2_high", high_a, 5);

    // Crash on the tick edge at score 2 drops the tick and the pulse
    pulse_a(1, 0);
    wait_n(11);
    pulse_a(0, 1);
    check("lit_tickcrash_state", state_a, 2);
    check("lit_tickcrash_score", score_a, 2);
    check("lit_tickcrash_ms", ms_a, 0);

    // Milestone at 6 and saturation at 7
    pulse_a(1, 0);
    wait_n(24);
    check("lit_score6", score_a, 6);
    check("lit_ms6", ms_a, 1);
    wait_n(20);
    check("lit_sat_score", score_a, 7);
    check("lit_sat_ms", ms_a, 0);
    pulse_a(0, 1);
    check("lit_sat_high", high_a, 7);

    // Instance B: high score 9, reset mid-run at score 4
    pulse_b(1, 0);
    wait_n(18);
    pulse_b(0, 1);
    check("lit_b_high9", high_b, 9);
    pulse_b(1, 0);
    wait_n(8);
    check("lit_b_score4", score_b, 4);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("lit_b_rst_state", state_b, 0);
    check("lit_b_rst_score", score_b, 0);
    check("lit_b_rst_high", high_b, 0);
    wait_n(5);
    check("lit_b_rst_idle", state_b, 0);

    // start and crash together in IDLE -> RUN
    pulse_b(1, 1);
    check("lit_b_both_state", state_b, 1);

    // BCD carries
    wait_n(198);
    check("lit_b_bcd99", bcd_b, 16'h0099);
    wait_n(2);
    check("lit_b_score100", score_b, 100);
    check("lit_b_bcd100", bcd_b, 16'h0100);
    wait_n(1200);
    check("lit_b_score700", score_b, 700);
    check("lit_b_ms700", ms_b, 1);
    wait_n(598);
    check("lit_b_bcd999", bcd_b, 16'h0999);
    wait_n(2);
    check("lit_b_bcd1000", bcd_b, 16'h1000);
    wait_n(17998);
    check("lit_b_score9999", score_b, 9999);
    wait_n(20);
    check("lit_b_bcd9999", bcd_b, 16'h9999);
    pulse_b(0, 1);
    check("lit_b_high9999", high_b, 9999);

    wait_n(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
